// File: rtl/tlc_pkg.sv
// Shared types and constants for the two-road traffic-light controller.
// States, lamp encodings and small elaboration-time helpers.
package tlc_pkg;

  typedef enum logic [2:0] {
    RED_TO_NS = 3'd0,
    NS_GREEN  = 3'd1,
    NS_YELLOW = 3'd2,
    RED_TO_EW = 3'd3,
    EW_GREEN  = 3'd4,
    EW_YELLOW = 3'd5
  } tlc_state_e;

  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;

  // Returns {ns_lamp, ew_lamp} for a given state.
  function automatic logic [5:0] lamps_for(input tlc_state_e s);
    logic [5:0] l;
    l = {LAMP_RED, LAMP_RED};
    case (s)
      NS_GREEN:  l = {LAMP_GRN, LAMP_RED};
      NS_YELLOW: l = {LAMP_YEL, LAMP_RED};
      EW_GREEN:  l = {LAMP_RED, LAMP_GRN};
      EW_YELLOW: l = {LAMP_RED, LAMP_YEL};
      default:   l = {LAMP_RED, LAMP_RED};
    endcase
    return l;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/tlc_phase_timer.sv
// Per-phase cycle counter: clears on request, counts up once per cycle and
// sticks at SAT_VAL instead of wrapping.
module tlc_phase_timer #(
  parameter int               WIDTH   = 6,
  parameter logic [WIDTH-1:0] SAT_VAL = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      count <= '0;
    end else if (count != SAT_VAL) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/traffic_light_ctrl.sv
// Two-road (NS/EW) traffic-light controller with min/max green, yellow and all-red clearance.
// Define TLC_PED_WALK_EN to add the pedestrian request/walk ports and the walk all-red.
module traffic_light_ctrl
  import tlc_pkg::*;
#(
  parameter int MIN_GREEN = 8,
  parameter int MAX_GREEN = 32,
  parameter int YELLOW    = 4,
  parameter int ALL_RED   = 2,
  parameter int PED_WALK  = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ns_car,
  input  logic       ew_car,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic [2:0] phase
`ifdef TLC_PED_WALK_EN
  ,
  input  logic       ped_req,
  output logic       ped_walk
`endif
);

  localparam int T_MAX = max2(max2(MIN_GREEN, MAX_GREEN), max2(max2(YELLOW, ALL_RED), PED_WALK));
  localparam int TW    = $clog2(T_MAX + 1);

  localparam logic [TW-1:0] MIN_T = TW'(MIN_GREEN - 1);
  localparam logic [TW-1:0] MAX_T = TW'(MAX_GREEN - 1);
  localparam logic [TW-1:0] YEL_T = TW'(YELLOW - 1);
  localparam logic [TW-1:0] RED_T = TW'(ALL_RED - 1);
  localparam logic [TW-1:0] SAT_T = TW'(MAX_GREEN);

  tlc_state_e    state;
  tlc_state_e    state_next;
  logic [TW-1:0] timer;
  logic [TW-1:0] red_last;
  logic          timer_clr;
  logic          ped_demand;

  // Timer restarts from zero on the first cycle of every new state.
  assign timer_clr = (state_next != state);

  tlc_phase_timer #(
    .WIDTH   (TW),
    .SAT_VAL (SAT_T)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (timer_clr),
    .count (timer)
  );

`ifdef TLC_PED_WALK_EN
  localparam logic [TW-1:0] WALK_T = TW'(PED_WALK - 1);

  logic ped_pending;
  logic walk_q;
  logic next_is_red;
  logic red_entry;

  assign next_is_red = (state_next == RED_TO_NS) || (state_next == RED_TO_EW);
  assign red_entry   = next_is_red && timer_clr;
  assign ped_demand  = ped_pending;
  assign red_last    = walk_q ? WALK_T : RED_T;
  assign ped_walk    = walk_q;

  // A pending request is consumed by the all-red it turns into a walk;
  // a press arriving on that same edge re-arms for the next round.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ped_pending <= 1'b0;
      walk_q      <= 1'b0;
    end else if (red_entry) begin
      ped_pending <= ped_req;
      walk_q      <= ped_pending;
    end else begin
      if (ped_req) ped_pending <= 1'b1;
      if (!next_is_red) walk_q <= 1'b0;
    end
  end
`else
  assign ped_demand = 1'b0;
  assign red_last   = RED_T;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= RED_TO_NS;
    end else begin
      state <= state_next;
    end
  end

  // Green yields only past MIN_GREEN with cross demand, and only early if own road is empty.
  always_comb begin
    state_next = state;
    case (state)
      RED_TO_NS: if (timer == red_last) state_next = NS_GREEN;
      NS_GREEN:  if ((timer >= MIN_T) && (ew_car || ped_demand) &&
                     (!ns_car || (timer >= MAX_T))) state_next = NS_YELLOW;
      NS_YELLOW: if (timer == YEL_T) state_next = RED_TO_EW;
      RED_TO_EW: if (timer == red_last) state_next = EW_GREEN;
      EW_GREEN:  if ((timer >= MIN_T) && (ns_car || ped_demand) &&
                     (!ew_car || (timer >= MAX_T))) state_next = EW_YELLOW;
      EW_YELLOW: if (timer == YEL_T) state_next = RED_TO_NS;
      default:   state_next = RED_TO_NS;
    endcase
  end

  // Lamps are loaded from the next state so they change on the same edge as phase.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ns_light <= LAMP_RED;
      ew_light <= LAMP_RED;
    end else begin
      {ns_light, ew_light} <= lamps_for(state_next);
    end
  end

  assign phase = state;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Self-checking bench for traffic_light_ctrl: cycle model feeds an expected queue,
// plus per-cycle lamp safety, phase order and phase-length checks.
module tb_traffic_light_ctrl;
  import tlc_pkg::*;

  localparam int MIN_G = 8;
  localparam int MAX_G = 32;
  localparam int YEL   = 4;
  localparam int AR    = 2;
  localparam int PW    = 6;
`ifdef TLC_PED_WALK_EN
  localparam bit PED_EN = 1'b1;
`else
  localparam bit PED_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ns_car = 1'b0;
  logic       ew_car = 1'b0;
  logic       ped_req = 1'b0;
  logic [2:0] ns_light;
  logic [2:0] ew_light;
  logic [2:0] phase;
  wire        ped_walk;

  always #5 clk = ~clk;

  traffic_light_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ns_car   (ns_car),
    .ew_car   (ew_car),
    .ns_light (ns_light),
    .ew_light (ew_light),
    .phase    (phase)
`ifdef TLC_PED_WALK_EN
    ,
    .ped_req  (ped_req),
    .ped_walk (ped_walk)
`endif
  );
`ifndef TLC_PED_WALK_EN
  assign ped_walk = 1'b0;
`endif

  // scoreboard
  logic [9:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model
  int m_state = 0;
  int m_cnt = 0;
  bit m_pend = 1'b0;
  bit m_walk = 1'b0;

  task automatic model_step(input bit r, input bit n, input bit e, input bit p);
    int nxt;
    if (!r) begin
      m_state = 0; m_cnt = 0; m_pend = 1'b0; m_walk = 1'b0;
    end else begin
      nxt = m_state;
      case (m_state)
        0, 3: if (m_cnt == (m_walk ? PW : AR) - 1) nxt = m_state + 1;
        1: if (m_cnt >= MIN_G - 1 && (e || m_pend) && (!n || m_cnt >= MAX_G - 1)) nxt = 2;
        4: if (m_cnt >= MIN_G - 1 && (n || m_pend) && (!e || m_cnt >= MAX_G - 1)) nxt = 5;
        default: if (m_cnt == YEL - 1) nxt = (m_state + 1) % 6;
      endcase
      if (nxt != m_state) begin
        m_cnt = 0;
        if (nxt == 0 || nxt == 3) begin
          m_walk = m_pend;
          m_pend = PED_EN && p;
        end else begin
          m_walk = 1'b0;
          if (PED_EN && p) m_pend = 1'b1;
        end
        m_state = nxt;
      end else begin
        m_cnt++;
        if (PED_EN && p) m_pend = 1'b1;
      end
    end
  endtask

  function automatic logic [2:0] lamp_exp(input int st, input int grn_st);
    if (st == grn_st) return LAMP_GRN;
    if (st == grn_st + 1) return LAMP_YEL;
    return LAMP_RED;
  endfunction

  // observation history
  logic [2:0] prev_ns, prev_ew, prev_phase;
  logic       prev_walk;
  bit         prev_valid = 1'b0;
  int         phase_run = 0;
  int         green_len = 0;
  int         walk_cycles = 0;

  task automatic cycle(input bit r, input bit n, input bit e, input bit p);
    logic [9:0] got;
    int exp_len;
    rst_n = r; ns_car = n; ew_car = e; ped_req = p;
    model_step(r, n, e, p);
    exp_q.push_back({m_walk, 3'(m_state), lamp_exp(m_state, 1), lamp_exp(m_state, 4)});
    @(posedge clk);
    #1;
    got = {ped_walk, phase, ns_light, ew_light};
    if (exp_q.size() == 0) check_eq("queue_empty", 32'd0, 32'd1);
    else check_eq("cycle", 32'(got), 32'(exp_q.pop_front()));
    check_eq("ns_onehot", 32'($onehot(ns_light)), 32'd1);
    check_eq("ew_onehot", 32'($onehot(ew_light)), 32'd1);
    check_eq("both_not_red", 32'(ns_light != LAMP_RED && ew_light != LAMP_RED), 32'd0);
    if (ped_walk) walk_cycles++;
    if (!r) begin
      phase_run = 1;
    end else if (prev_valid) begin
      if (prev_ns == LAMP_GRN) check_eq("ns_grn_then", 32'(ns_light == LAMP_RED), 32'd0);
      if (prev_ew == LAMP_GRN) check_eq("ew_grn_then", 32'(ew_light == LAMP_RED), 32'd0);
      if (prev_ns == LAMP_YEL) check_eq("ns_yel_then", 32'(ns_light == LAMP_GRN), 32'd0);
      if (prev_ew == LAMP_YEL) check_eq("ew_yel_then", 32'(ew_light == LAMP_GRN), 32'd0);
      if (phase != prev_phase) begin
        check_eq("phase_order", 32'(phase), 32'((int'(prev_phase) + 1) % 6));
        exp_len = 0;
        if (prev_phase == NS_YELLOW || prev_phase == EW_YELLOW) exp_len = YEL;
        else if (prev_phase == RED_TO_NS || prev_phase == RED_TO_EW) exp_len = prev_walk ? PW : AR;
        else exp_len = green_len;
        if (exp_len != 0) check_eq("phase_len", 32'(phase_run), 32'(exp_len));
        phase_run = 1;
      end else begin
        phase_run++;
      end
    end
    prev_ns = ns_light; prev_ew = ew_light; prev_phase = phase; prev_walk = ped_walk;
    prev_valid = 1'b1;
  endtask

  task automatic do_reset();
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    // reset state and release into NS green
    green_len = 0;
    do_reset();
    check_eq("rst_phase", 32'(phase), 32'(RED_TO_NS));
    check_eq("rst_lamps", 32'({ns_light, ew_light}), 32'({LAMP_RED, LAMP_RED}));
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("red_hold", 32'(phase), 32'(RED_TO_NS));
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("ns_green_after_2", 32'(ns_light), 32'(LAMP_GRN));
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("idle_hold_ns", 32'(phase), 32'(NS_GREEN));

    // only EW demand: NS green exactly MIN_GREEN
    green_len = MIN_G;
    do_reset();
    for (int i = 0; i < 30; i++) cycle(1'b1, 1'b0, 1'b1, 1'b0);
    check_eq("ew_green_reached", 32'(phase), 32'(EW_GREEN));

    // both roads busy: alternate every MAX_GREEN
    green_len = MAX_G;
    do_reset();
    for (int i = 0; i < 250; i++) cycle(1'b1, 1'b1, 1'b1, 1'b0);

    // NS only for 200 cycles: timer saturates, yields at once when EW arrives
    green_len = 0;
    do_reset();
    for (int i = 0; i < 200; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0);
    check_eq("ns_long_hold", 32'(phase), 32'(NS_GREEN));
    cycle(1'b1, 1'b1, 1'b1, 1'b0);
    check_eq("sat_yield", 32'(phase), 32'(NS_YELLOW));
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1, 1'b1, 1'b0);

    // sensor pulse in yellow, then reset in the middle of EW green
    green_len = MIN_G;
    do_reset();
    for (int i = 0; i < 40 && phase != NS_YELLOW; i++) cycle(1'b1, 1'b0, 1'b1, 1'b0);
    check_eq("reach_ns_yellow", 32'(phase), 32'(NS_YELLOW));
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("ew_green_mid", 32'(phase), 32'(EW_GREEN));
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("abort_phase", 32'(phase), 32'(RED_TO_NS));
    check_eq("abort_ew_red", 32'(ew_light), 32'(LAMP_RED));
    for (int i = 0; i < 20; i++) cycle(1'b1, $urandom_range(0, 1), 1'b0, 1'b0);

    // random sensor traffic
    green_len = 0;
    do_reset();
    for (int i = 0; i < 400; i++)
      cycle(1'b1, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, 1'b0);

`ifdef TLC_PED_WALK_EN
    // single pedestrian press with no cars
    do_reset();
    walk_cycles = 0;
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 40; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("walk_len", 32'(walk_cycles), 32'(PW));
    check_eq("ped_to_ew", 32'(phase), 32'(EW_GREEN));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
